// File: rtl/rgb_to_gray_axis_if.sv
// AXI4-Stream channel bundle (valid/ready/data/last/user) with a parameterised data width.
interface rgb_to_gray_axis_if #(
  parameter int W = 8
);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tlast;
  logic         tuser;

  modport master (output tvalid, tdata, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/rgb_to_gray_axis.sv
// RGB888 to luma converter with line-structure checking and regenerated tlast.
// Two-stage fully stallable pipeline, one pixel per clock.
module rgb_to_gray_axis #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 1920
) (
  input  logic               clk,
  input  logic               rst,
  rgb_to_gray_axis_if.slave  s_axis,
  rgb_to_gray_axis_if.master m_axis,
  input  logic [15:0]        img_width,
  output logic               err_short_line,
  output logic               err_long_line,
  output logic               err_sof_midline
);

  localparam int          PW        = DATA_WIDTH + 8;
  localparam logic [15:0] WIDTH_RST = 16'(IMG_WIDTH);

  logic                  en;
  logic                  acc;
  logic [DATA_WIDTH-1:0] r, g, b;
  logic [15:0]           wq, col;
  logic [15:0]           w_eff, col_eff, last_col;
  logic                  at_end, eol;
  logic [PW-1:0]         p_r, p_g, p_b;
  logic                  v1, u1, l1;
  logic [DATA_WIDTH-1:0] y;

  assign en            = !m_axis.tvalid || m_axis.tready;
  assign s_axis.tready = en;
  assign acc           = s_axis.tvalid && en;

  assign r = s_axis.tdata[3*DATA_WIDTH-1 -: DATA_WIDTH];
  assign g = s_axis.tdata[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign b = s_axis.tdata[DATA_WIDTH-1:0];

  // A SOF beat already uses the width it samples; a zero width is ignored.
  assign w_eff    = (s_axis.tuser && img_width != 16'd0) ? img_width : wq;
  assign col_eff  = s_axis.tuser ? 16'd0 : col;
  assign last_col = w_eff - 16'd1;
  assign at_end   = (col_eff == last_col);
  assign eol      = at_end || s_axis.tlast;

  // Rounded weighted sum; cannot exceed PW bits, so no saturation is needed.
  assign y = DATA_WIDTH'((p_r + p_g + p_b + PW'(128)) >> 8);

  // NOTE: every register here uses non-blocking assignment so all stages sample
  // the pre-edge values of each other, which is what makes this a pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the product registers are cleared too; they are cheap and this keeps
      // m_axis_tdata deterministic from the first edge regardless of stall history.
      wq              <= WIDTH_RST;
      col             <= '0;
      err_short_line  <= 1'b0;
      err_long_line   <= 1'b0;
      err_sof_midline <= 1'b0;
      p_r             <= '0;
      p_g             <= '0;
      p_b             <= '0;
      v1              <= 1'b0;
      u1              <= 1'b0;
      l1              <= 1'b0;
      m_axis.tvalid   <= 1'b0;
      m_axis.tdata    <= '0;
      m_axis.tlast    <= 1'b0;
      m_axis.tuser    <= 1'b0;
    end else begin
      err_short_line  <= acc && s_axis.tlast && (col_eff < last_col);
      err_long_line   <= acc && at_end && !s_axis.tlast;
      err_sof_midline <= acc && s_axis.tuser && (col != 16'd0);

      if (acc) begin
        if (s_axis.tuser && img_width != 16'd0) wq <= img_width;
        col <= eol ? 16'd0 : col_eff + 16'd1;
      end

      if (en) begin
        p_r <= PW'(r) * PW'(77);
        p_g <= PW'(g) * PW'(150);
        p_b <= PW'(b) * PW'(29);
        v1  <= acc;
        u1  <= acc && s_axis.tuser;
        l1  <= acc && eol;

        m_axis.tvalid <= v1;
        m_axis.tdata  <= y;
        m_axis.tlast  <= l1;
        m_axis.tuser  <= u1;
      end
    end
  end

endmodule

// File: tb/tb_rgb_to_gray_axis.sv
// Self-checking bench for rgb_to_gray_axis: directed steps, reference model, output scoreboard.
module tb_rgb_to_gray_axis;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] img_width = 16'd0;
  logic        err_short_line, err_long_line, err_sof_midline;

  rgb_to_gray_axis_if #(.W(24)) s_if ();
  rgb_to_gray_axis_if #(.W(8))  m_if ();

  rgb_to_gray_axis #(.DATA_WIDTH(8), .IMG_WIDTH(1920)) dut (
    .clk             (clk),
    .rst             (rst),
    .s_axis          (s_if),
    .m_axis          (m_if),
    .img_width       (img_width),
    .err_short_line  (err_short_line),
    .err_long_line   (err_long_line),
    .err_sof_midline (err_sof_midline)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] y;
    logic       last;
    logic       user;
  } beat_t;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_err    = 0;
  int    ready_mode = 1;  // 0: hold low, 1: hold high, 2: random
  logic [15:0] m_wq  = 16'd1920;
  logic [15:0] m_col = 16'd0;
  int exp_short = 0, exp_long = 0, exp_sof = 0;
  int cnt_short = 0, cnt_long = 0, cnt_sof = 0;
  logic       held_v = 1'b0;
  logic [9:0] held   = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gray(input logic [23:0] p);
    int s;
    s = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]) + 128;
    return 8'(s >> 8);
  endfunction

  // Downstream ready generation and error-pulse counting, just after each edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_if.tready = 1'b0;
      1:       m_if.tready = 1'b1;
      default: m_if.tready = 1'($urandom_range(0, 1));
    endcase
    cnt_short += int'(err_short_line);
    cnt_long  += int'(err_long_line);
    cnt_sof   += int'(err_sof_midline);
  end

  // Output scoreboard and stall-stability check, sampled mid-cycle.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (m_if.tvalid && held_v)
        check("hold_stable", 32'({m_if.tdata, m_if.tlast, m_if.tuser}), 32'(held));
      if (m_if.tvalid && m_if.tready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'(m_if.tdata), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("y", 32'(m_if.tdata), 32'(e.y));
          check("tlast", 32'(m_if.tlast), 32'(e.last));
          check("tuser", 32'(m_if.tuser), 32'(e.user));
        end
      end
      held_v = m_if.tvalid && !m_if.tready;
      held   = {m_if.tdata, m_if.tlast, m_if.tuser};
    end
  end

  // Drive one beat, wait for acceptance, then check the error pulses it caused.
  task automatic send(input logic [23:0] rgb, input logic last, input logic user);
    logic [15:0] w, c;
    logic        eol, es, el, ef;
    bit          acc = 1'b0;
    w   = (user && img_width != 16'd0) ? img_width : m_wq;
    c   = user ? 16'd0 : m_col;
    eol = (c == w - 16'd1) || last;
    es  = last && (c < w - 16'd1);
    el  = (c == w - 16'd1) && !last;
    ef  = user && (m_col != 16'd0);
    sb.push_back(beat_t'{gray(rgb), eol, user});
    s_if.tvalid = 1'b1;
    s_if.tdata  = rgb;
    s_if.tlast  = last;
    s_if.tuser  = user;
    for (int t = 0; t < 500 && !acc; t++) begin
      @(negedge clk);
      acc = s_if.tready;
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 1'b0;
    if (!acc) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      check("err_short", 32'(err_short_line), 32'(es));
      check("err_long", 32'(err_long_line), 32'(el));
      check("err_sof", 32'(err_sof_midline), 32'(ef));
      m_wq  = w;
      m_col = eol ? 16'd0 : c + 16'd1;
      exp_short += int'(es);
      exp_long  += int'(el);
      exp_sof   += int'(ef);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sb.size() != 0; t++) @(posedge clk);
    #1;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_counts();
    check("n_short", 32'(cnt_short), 32'(exp_short));
    check("n_long", 32'(cnt_long), 32'(exp_long));
    check("n_sof", 32'(cnt_sof), 32'(exp_sof));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    ready_mode  = 1;
    rst = 1'b1;
    idle(3);
    check("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    check("rst_tdata", 32'(m_if.tdata), 32'd0);
    check("rst_errs", 32'({err_short_line, err_long_line, err_sof_midline}), 32'd0);
    check("rst_s_tready", 32'(s_if.tready), 32'd1);
    rst = 1'b0;
    idle(1);

    // Colour primaries, first output latency.
    send(24'hFFFFFF, 1'b0, 1'b0);
    check("lat_not_early", 32'(m_if.tvalid), 32'd0);
    lat = 0;
    while (!m_if.tvalid && lat < 3) begin
      idle(1);
      lat++;
    end
    check("lat_bound", 32'(lat <= 2), 32'd1);
    check("lat_white", 32'(m_if.tdata), 32'd255);
    send(24'hFF0000, 1'b0, 1'b0);
    send(24'h00FF00, 1'b0, 1'b0);
    send(24'h0000FF, 1'b0, 1'b0);
    drain();

    // Three well-formed lines of width 4.
    img_width = 16'd4;
    for (int i = 0; i < 12; i++)
      send(24'($urandom), 1'((i % 4) == 3), 1'(i == 0));
    drain();
    check_counts();

    // Long line: 6 beats, no tlast.
    for (int i = 0; i < 6; i++)
      send(24'($urandom), 1'b0, 1'(i == 0));
    drain();
    check("long_pulses", 32'(cnt_long), 32'(exp_long));

    // SOF while mid-line, short line, then SOF at column 2.
    send(24'h102030, 1'b0, 1'b1);
    send(24'h405060, 1'b1, 1'b0);
    send(24'h708090, 1'b0, 1'b0);
    send(24'hA0B0C0, 1'b0, 1'b0);
    send(24'hD0E0F0, 1'b0, 1'b1);
    drain();
    check_counts();

    // Width 1: every beat ends a line.
    img_width = 16'd1;
    send(24'h123456, 1'b0, 1'b1);
    send(24'h654321, 1'b0, 1'b0);
    send(24'hABCDEF, 1'b1, 1'b0);
    drain();
    check_counts();

    // Random back-pressure over a 1000-pixel stream of width 37.
    img_width  = 16'd37;
    ready_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      send(24'($urandom), 1'((i % 37) == 36), 1'(i == 0));
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    ready_mode = 1;
    drain();
    check_counts();

    // Reset during a stall with two beats in flight.
    ready_mode = 0;
    idle(2);
    send(24'h112233, 1'b0, 1'b0);
    send(24'h445566, 1'b0, 1'b0);
    s_if.tvalid = 1'b1;
    s_if.tdata  = 24'hFFFFFF;
    s_if.tlast  = 1'b1;
    s_if.tuser  = 1'b1;
    img_width   = 16'd4;
    idle(1);
    check("stall_tvalid", 32'(m_if.tvalid), 32'd1);
    check("stall_s_tready", 32'(s_if.tready), 32'd0);
    rst = 1'b1;
    idle(1);
    check("mid_rst_tvalid", 32'(m_if.tvalid), 32'd0);
    check("mid_rst_tdata", 32'(m_if.tdata), 32'd0);
    check("mid_rst_tlast_tuser", 32'({m_if.tlast, m_if.tuser}), 32'd0);
    check("mid_rst_errs", 32'({err_short_line, err_long_line, err_sof_midline}), 32'd0);
    check("mid_rst_s_tready", 32'(s_if.tready), 32'd1);
    idle(1);
    rst = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    sb.delete();
    m_wq  = 16'd1920;
    m_col = 16'd0;
    check_counts();
    exp_short = 0; exp_long = 0; exp_sof = 0;
    cnt_short = 0; cnt_long = 0; cnt_sof = 0;
    ready_mode = 1;
    idle(2);
    check("post_rst_empty", 32'(m_if.tvalid), 32'd0);

    // Restart without SOF: width must be back to 1920 and column at 0.
    for (int i = 0; i < 5; i++)
      send(24'($urandom), 1'b0, 1'b0);
    drain();
    check_counts();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
